// File: rtl/caravel_timer_pkg.sv
// Register map and CONFIG bit layout shared by the timer and its bench.
package caravel_timer_pkg;

    localparam logic [1:0] ADDR_CONFIG = 2'd0;
    localparam logic [1:0] ADDR_VALUE  = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CFG_ENABLE  = 0;
    localparam int CFG_ONESHOT = 1;
    localparam int CFG_UPDOWN  = 2;
    localparam int CFG_IRQ_ENA = 3;
    localparam int CFG_BITS    = 4;

endpackage

// File: rtl/caravel_timer.sv
// Programmable up/down counter/timer with one-shot or continuous reload and a terminal-count irq.
// Latency: rdata one cycle after a read select; irq is asserted in the terminal-count cycle itself.
// Backpressure: none; the bus is always ready and every access completes in one cycle.
module caravel_timer
    import caravel_timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    logic [CFG_BITS-1:0] cfg;
    logic [WIDTH-1:0]    value;
    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    value_nxt;
    logic                auto_clear;
    logic                at_term;

    logic wr_cfg, wr_val, wr_dat, rd_en;
    logic enable, oneshot, count_up, irq_ena;

    assign wr_cfg = sel && we && (addr == ADDR_CONFIG);
    assign wr_val = sel && we && (addr == ADDR_VALUE);
    assign wr_dat = sel && we && (addr == ADDR_DATA);
    assign rd_en  = sel && !we;

    assign enable   = cfg[CFG_ENABLE];
    assign oneshot  = cfg[CFG_ONESHOT];
    assign count_up = cfg[CFG_UPDOWN];
    assign irq_ena  = cfg[CFG_IRQ_ENA];

    // Terminal is equality only: an up-count started above DATA wraps without an event.
    assign at_term = count_up ? (value == data) : (value == '0);
    assign irq     = enable && irq_ena && at_term;

    always_comb begin
        value_nxt  = value;
        auto_clear = 1'b0;
        if (enable) begin
            if (count_up) begin
                if (value < data)
                    value_nxt = value + WIDTH'(1);
                else if (oneshot)
                    auto_clear = 1'b1;
                else
                    value_nxt = '0;
            end else begin
                if (value != '0)
                    value_nxt = value - WIDTH'(1);
                else if (oneshot)
                    auto_clear = 1'b1;
                else
                    value_nxt = data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg   <= '0;
            value <= '0;
            data  <= '0;
            rdata <= '0;
        end else begin
            // A firmware CONFIG write wins over the one-shot self-disable.
            if (wr_cfg)
                cfg <= wdata[CFG_BITS-1:0];
            else if (auto_clear)
                cfg[CFG_ENABLE] <= 1'b0;

            value <= wr_val ? wdata : value_nxt;

            if (wr_dat)
                data <= wdata;

            if (rd_en) begin
                case (addr)
                    ADDR_CONFIG: rdata <= {{(WIDTH-CFG_BITS){1'b0}}, cfg};
                    ADDR_VALUE:  rdata <= value;
                    ADDR_DATA:   rdata <= data;
                    default:     rdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_caravel_timer.sv
// Directed bench: stimulus pushes expected read data / irq counts, a negedge monitor checks them.
module tb_caravel_timer;
    import caravel_timer_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    caravel_timer #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clock = ~clock;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_pend = 1'b0;
    int          irq_hi = 0;
    logic        irq_chk = 1'b0;
    int          irq_exp = 0;
    string       irq_name = "";
    logic        done = 1'b0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clock) rd_pend <= sel && !we && !reset;

    always @(negedge clock) begin
        if (irq === 1'b1)
            irq_hi = irq_hi + 1;
        if (rd_pend) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_read: rdata=%h with no expectation queued", rdata);
            end else begin
                logic [31:0] e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (rdata !== e) begin
                    bad = bad + 1;
                    $display("FAIL %s: rdata=%h expected=%h", n, rdata, e);
                end
            end
        end
        if (irq_chk) begin
            total = total + 1;
            if (irq_hi != irq_exp) begin
                bad = bad + 1;
                $display("FAIL %s: irq cycles=%0d expected=%0d", irq_name, irq_hi, irq_exp);
            end
        end
        if (done) begin
            total = total + 1;
            if (exp_q.size() != 0) begin
                bad = bad + 1;
                $display("FAIL leftover_reads: %0d expected reads never returned", exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clock); #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        sel = 1'b1; we = 1'b0; addr = a;
        @(posedge clock); #1;
        sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk_irq(input int e, input string n);
        irq_exp = e; irq_name = n; irq_chk = 1'b1;
        @(posedge clock); #1;
        irq_chk = 1'b0;
    endtask

    int base;
    logic [31:0] seq2 [6];

    initial begin
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // 1: reset values, reserved address
        rd(ADDR_CONFIG, 32'h0, "reset_config");
        rd(ADDR_VALUE,  32'h0, "reset_value");
        rd(ADDR_DATA,   32'h0, "reset_data");
        chk_irq(0, "reset_irq");
        wr(ADDR_RSVD, 32'hffff_ffff);
        rd(ADDR_RSVD,   32'h0, "rsvd_read");
        rd(ADDR_CONFIG, 32'h0, "rsvd_no_alias");

        // 2: down continuous with reload, irq disabled
        base = irq_hi;
        seq2 = '{32'h3, 32'h2, 32'h1, 32'h0, 32'h11, 32'h10};
        wr(ADDR_DATA, 32'h11);
        wr(ADDR_VALUE, 32'h3);
        wr(ADDR_CONFIG, 32'h1);
        for (int i = 0; i < 6; i++) rd(ADDR_VALUE, seq2[i], "down_cont_seq");
        wr(ADDR_CONFIG, 32'h0);
        rd(ADDR_VALUE, 32'h0e, "disable_late");
        rd(ADDR_VALUE, 32'h0e, "disabled_frozen");
        chk_irq(base, "down_cont_no_irq");

        // 3: down one-shot
        base = irq_hi;
        wr(ADDR_VALUE, 32'h0f);
        wr(ADDR_CONFIG, 32'h3);
        idle(14);
        rd(ADDR_VALUE, 32'h1, "oneshot_dn_14");
        rd(ADDR_VALUE, 32'h0, "oneshot_dn_15");
        idle(10);
        rd(ADDR_VALUE,  32'h0, "oneshot_dn_hold");
        rd(ADDR_CONFIG, 32'h2, "oneshot_dn_cfg");
        chk_irq(base, "oneshot_dn_no_irq");

        // 4: up continuous with irq
        base = irq_hi;
        wr(ADDR_DATA, 32'h12b4);
        wr(ADDR_VALUE, 32'h12b0);
        wr(ADDR_CONFIG, 32'hD);
        for (int i = 0; i < 5; i++) rd(ADDR_VALUE, 32'h12b0 + i, "up_cont_seq");
        rd(ADDR_VALUE, 32'h0, "up_cont_wrap");
        chk_irq(base + 1, "up_cont_irq_once");
        wr(ADDR_CONFIG, 32'h0);

        // 5: up one-shot with irq
        base = irq_hi;
        wr(ADDR_DATA, 32'h0f);
        wr(ADDR_VALUE, 32'h0);
        wr(ADDR_CONFIG, 32'hF);
        idle(14);
        rd(ADDR_VALUE, 32'h0e, "oneshot_up_14");
        rd(ADDR_VALUE, 32'h0f, "oneshot_up_15");
        idle(5);
        rd(ADDR_VALUE,  32'h0f, "oneshot_up_hold");
        rd(ADDR_CONFIG, 32'hE,  "oneshot_up_cfg");
        chk_irq(base + 1, "oneshot_up_irq_once");

        // 6: VALUE overwrite mid-count, DATA write, reset mid-count
        wr(ADDR_DATA, 32'h100);
        wr(ADDR_CONFIG, 32'h1);
        idle(3);
        wr(ADDR_VALUE, 32'hdcba7cf3);
        rd(ADDR_VALUE, 32'hdcba7cf3, "value_overwrite");
        rd(ADDR_VALUE, 32'hdcba7cf2, "resume_1");
        rd(ADDR_VALUE, 32'hdcba7cf1, "resume_2");
        wr(ADDR_DATA, 32'h55);
        rd(ADDR_VALUE, 32'hdcba7cef, "data_wr_no_disturb");
        base = irq_hi;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        rd(ADDR_CONFIG, 32'h0, "midreset_config");
        rd(ADDR_VALUE,  32'h0, "midreset_value");
        rd(ADDR_DATA,   32'h0, "midreset_data");
        idle(3);
        chk_irq(base, "midreset_irq");

        done = 1'b1;
        @(posedge clock);
        @(posedge clock);
    end

endmodule
